// File: rtl/lc3b_types.sv
// Shared LC-3b types for the multi-cycle ALU: opcode encoding and controller states.
// ALU_MC_DIV_EN makes alu_div an iterative opcode; otherwise it decodes as unknown.
package lc3b_types;

  // Encodings 10-15 are reserved and report resp_err.
  typedef enum logic [3:0] {
    alu_add      = 4'd0,
    alu_and      = 4'd1,
    alu_not      = 4'd2,
    alu_pass     = 4'd3,
    alu_sll      = 4'd4,
    alu_srl      = 4'd5,
    alu_sra      = 4'd6,
    alu_bytemask = 4'd7,
    alu_mul      = 4'd8,
    alu_div      = 4'd9
  } lc3b_mcaluop;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_iter = 2'd1,
    st_done = 2'd2
  } alu_mc_state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return (op == alu_mul) || (op == alu_div);
`else
    return (op == alu_mul);
`endif
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath for alu_mc: shift-add multiply and, with ALU_MC_DIV_EN,
// restoring unsigned divide. res is the value after the step in progress.
module alu_mc_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
`ifdef ALU_MC_DIV_EN
  input  logic             div_sel,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] prod_nxt;

  assign prod_nxt = sh_b[0] ? (acc + sh_a) : acc;

`ifdef ALU_MC_DIV_EN
  logic             div_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_nxt;

  // sh_a holds the dividend and fills with quotient bits from the bottom;
  // a zero divisor naturally yields an all-ones quotient.
  assign trial   = {rem, sh_a[WIDTH-1]};
  assign diff    = trial - {1'b0, sh_b};
  assign q_bit   = ~diff[WIDTH];
  assign quo_nxt = {sh_a[WIDTH-2:0], q_bit};
  assign rem_nxt = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign res     = div_q ? quo_nxt : prod_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
      rem   <= '0;
    end else if (load) begin
      div_q <= div_sel;
      rem   <= '0;
    end else if (step && div_q) begin
      rem   <= rem_nxt;
    end
  end
`else
  assign res = prod_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      sh_a <= '0;
      sh_b <= '0;
    end else if (load) begin
      acc  <= '0;
      sh_a <= a;
      sh_b <= b;
    end else if (step) begin
`ifdef ALU_MC_DIV_EN
      if (div_q) begin
        sh_a <= quo_nxt;
      end else begin
        acc  <= prod_nxt;
        sh_a <= sh_a << 1;
        sh_b <= sh_b >> 1;
      end
`else
      acc  <= prod_nxt;
      sh_a <= sh_a << 1;
      sh_b <= sh_b >> 1;
`endif
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle LC-3b ALU with valid/ready request and response channels.
// Optional iterative divide is enabled by defining ALU_MC_DIV_EN.
//
// state   | meaning
// st_idle | waiting for a request, req_ready high
// st_iter | multiply/divide stepping, counter counts down to 0
// st_done | result held on resp_f/resp_err until resp_ready
module alu_mc
  import lc3b_types::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_f,
  output logic             resp_err,
  output logic             busy
);

  alu_mc_state_e    state, state_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] f_q, f_nxt;
  logic             err_q, err_nxt;
  logic             load, step;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] sc_f;
  logic             sc_err;
  logic [SHW-1:0]   sh;

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
`ifdef ALU_MC_DIV_EN
    .div_sel (req_op == alu_div),
`endif
    .a       (req_a),
    .b       (req_b),
    .res     (iter_res)
  );

  // Single-cycle results; iterative and unknown opcodes fall to the error default.
  always_comb begin
    sc_f   = '0;
    sc_err = 1'b0;
    sh     = req_b[SHW-1:0];
    case (lc3b_mcaluop'(req_op))
      alu_add:      sc_f = req_a + req_b;
      alu_and:      sc_f = req_a & req_b;
      alu_not:      sc_f = ~req_a;
      alu_pass:     sc_f = req_a;
      alu_sll:      sc_f = req_a << sh;
      alu_srl:      sc_f = req_a >> sh;
      alu_sra:      sc_f = $signed(req_a) >>> sh;
      alu_bytemask: sc_f = {(WIDTH/8){req_a[7:0]}};
      default:      sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    f_nxt     = f_q;
    err_nxt   = err_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      st_idle: begin
        if (req_valid) begin
          if (is_iter_op(req_op)) begin
            state_nxt = st_iter;
            cnt_nxt   = SHW'(WIDTH - 1);
            load      = 1'b1;
`ifdef ALU_MC_DIV_EN
            err_nxt   = (req_op == alu_div) && (req_b == '0);
`else
            err_nxt   = 1'b0;
`endif
          end else begin
            state_nxt = st_done;
            f_nxt     = sc_f;
            err_nxt   = sc_err;
          end
        end
      end
      st_iter: begin
        step    = 1'b1;
        cnt_nxt = cnt - SHW'(1);
        if (cnt == '0) begin
          state_nxt = st_done;
          cnt_nxt   = '0;
          f_nxt     = iter_res;
        end
      end
      st_done: begin
        if (resp_ready) state_nxt = st_idle;
      end
      default: state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= st_idle;
      cnt   <= '0;
      f_q   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      f_q   <= f_nxt;
      err_q <= err_nxt;
    end
  end

  assign req_ready  = (state == st_idle);
  assign resp_valid = (state == st_done);
  assign busy       = (state != st_idle);
  assign resp_f     = f_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed cases then randomized ops with random backpressure.
module tb_alu_mc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         resp_ready = 1'b0;
  logic [3:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_ready, resp_valid, resp_err, busy;
  logic [W-1:0] resp_f;

  typedef struct {
    logic [W-1:0] f;
    logic         e;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_rr = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_f(resp_f), .resp_err(resp_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic void model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] f, output logic e, output int lat);
    int     ia, ib, sh, sa;
    longint p;
    ia = int'(a); ib = int'(b); sh = ib % W;
    f = '0; e = 1'b0; lat = 1;
    case (op)
      0: f = W'((ia + ib) % 65536);
      1: f = a & b;
      2: f = ~a;
      3: f = a;
      4: f = W'((ia << sh) % 65536);
      5: f = W'(ia >> sh);
      6: begin
        sa = (ia >= 32768) ? ia - 65536 : ia;
        f  = W'(sa >>> sh);
      end
      7: f = W'((ia % 256) * 257);
      8: begin
        p   = longint'(ia) * longint'(ib);
        f   = W'(p % 65536);
        lat = W + 1;
      end
`ifdef ALU_MC_DIV_EN
      9: begin
        lat = W + 1;
        if (ib == 0) begin f = '1; e = 1'b1; end
        else f = W'(ia / ib);
      end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    bit   ok = 1'b0;
    req_op = 4'(op); req_a = a; req_b = b; req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready stayed %0b, expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    model(op, a, b, x.f, x.e, x.lat);
    x.acc_cyc = cyc + 1;
    sb.push_back(x);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready && !resp_valid && sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: req_ready=%0b pending=%0d, expected idle with none pending", req_ready, sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares each response against the scoreboard and checks it is held.
  initial begin : monitor
    bit           in_resp;
    logic [W-1:0] hf;
    logic         he;
    exp_t         x;
    in_resp = 1'b0; hf = '0; he = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_resp = 1'b0;
      end else if (resp_valid) begin
        if (!in_resp) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got f=%0h err=%0b, expected no response", resp_f, resp_err);
          end else begin
            x = sb[0];
            chk("latency", cyc - x.acc_cyc + 1, x.lat);
            chk("resp_f", resp_f, x.f);
            chk("resp_err", resp_err, x.e);
          end
          hf = resp_f; he = resp_err; in_resp = 1'b1;
        end else begin
          chk("hold_f", resp_f, hf);
          chk("hold_err", resp_err, he);
        end
        if (resp_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          in_resp = 1'b0;
        end
      end
    end
  end

  initial begin : rr_driver
    forever begin
      @(posedge clk); #1;
      if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : main
    int n, bad;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_f", resp_f, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;

    issue(0, 16'hFFFF, 16'h0002);
    issue(6, 16'h8000, 16'h0013);
    issue(7, 16'h12AB, 16'h0000);
    issue(2, 16'h0F0F, 16'h0000);
    issue(4, 16'h0001, 16'hFFF4);
    wait_idle();

    issue(8, 16'h0123, 16'h0045);
    n = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (!busy) bad++;
    end
    chk("mul_ready_low_cycles", n, 17);
    chk("mul_busy_low_count", bad, 0);
    wait_idle();

    resp_ready = 1'b0;
    issue(1, 16'hF0F0, 16'h3C3C);
    req_valid = 1'b1; req_op = 4'd0; req_a = 16'h0001; req_b = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_resp_valid", resp_valid, 1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_back_to_idle", req_ready, 1);
    chk("bp_busy", busy, 0);
    wait_idle();

    issue(12, 16'h1234, 16'h5678);
    issue(9, 16'd100, 16'd7);
    issue(9, 16'd100, 16'd0);
    issue(15, 16'hFFFF, 16'hFFFF);
    wait_idle();

    issue(8, 16'h1357, 16'h2468);
    repeat (8) @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_resp_f", resp_f, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("abort_no_resp", n, 0);
    @(posedge clk); #1;
    issue(0, 16'd1, 16'd1);
    wait_idle();

    rand_rr = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue(int'($urandom_range(0, 15)), ra, rb);
    end
    rand_rr = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
